// File: rtl/ahb_interconnect_n_pkg.sv
// Shared definitions for the single-master AHB-style interconnect:
// response codes, data-phase state encoding and the default-slave index.
package ahb_interconnect_n_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // The default slave index is all-ones of the decode field; modules slice
  // this constant down to their IDX_W (decode fields wider than 8 bits are
  // not supported).
  localparam int unsigned   MAX_IDX_W = 8;
  localparam logic [MAX_IDX_W-1:0] DEF_ALL = '1;

endpackage

// File: rtl/ahb_interconnect_n_decode.sv
// Address-field decoder: field value f in 1..N_SLV selects slave f-1,
// anything else selects the built-in default slave.
import ahb_interconnect_n_pkg::*;

module addr_decode_n #(
  parameter int N_SLV = 3,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] field_i,
  input  logic             trans_i,
  output logic [N_SLV-1:0] sel_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             def_o
);

  localparam logic [IDX_W-1:0] DEF_IDX = DEF_ALL[IDX_W-1:0];

  // One-hot select (gated by trans_i) plus registered-phase index.
  always_comb begin
    sel_o = '0;
    idx_o = DEF_IDX;
    def_o = 1'b1;
    for (int k = 0; k < N_SLV; k++) begin
      if (field_i == IDX_W'(k + 1)) begin
        sel_o[k] = trans_i;
        idx_o    = IDX_W'(k);
        def_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_interconnect_n.sv
// Single-master, N-slave interconnect: address decode, data-phase slave
// tracking, response mux, default-slave ERROR and wait-state timeout.
import ahb_interconnect_n_pkg::*;

module ahb_interconnect_n #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int N_SLV   = 3,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_trans,
  input  logic [ADDR_W-1:0]       m_addr,
  input  logic                    m_write,
  input  logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_ready,
  output logic [1:0]              m_resp,
  output logic [N_SLV-1:0]        s_sel,
  output logic [ADDR_W-1:0]       s_addr,
  output logic                    s_write,
  output logic [DATA_W-1:0]       s_wdata,
  output logic                    s_readyin,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
  input  logic [N_SLV-1:0]        s_ready,
  input  logic [2*N_SLV-1:0]      s_resp,
  output logic                    timeout_evt
);

  localparam int               CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] DEF_IDX = DEF_ALL[IDX_W-1:0];

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   dp_idx_q, dp_idx_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;

  logic [IDX_W-1:0]   dec_idx;
  logic               dec_def;
  logic [IDX_W-1:0]   new_idx;
  logic [DATA_W-1:0]  slv_rdata;
  logic               slv_ready;
  logic [1:0]         slv_resp;

  // Select is forced low while in reset so slaves see no request.
  addr_decode_n #(
    .N_SLV (N_SLV),
    .IDX_W (IDX_W)
  ) u_dec (
    .field_i (m_addr[ADDR_W-1 -: IDX_W]),
    .trans_i (m_trans & ~rst),
    .sel_o   (s_sel),
    .idx_o   (dec_idx),
    .def_o   (dec_def)
  );

  assign new_idx   = dec_def ? DEF_IDX : dec_idx;
  assign s_addr    = m_addr;
  assign s_write   = m_write;
  assign s_wdata   = m_wdata;
  assign s_readyin = m_ready;

  // Pick the data-phase slave's rdata/ready/resp out of the flattened buses.
  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b0;
    slv_resp  = RESP_OKAY;
    for (int k = 0; k < N_SLV; k++) begin
      if (dp_idx_q == IDX_W'(k)) begin
        slv_rdata = s_rdata[k*DATA_W +: DATA_W];
        slv_ready = s_ready[k];
        slv_resp  = s_resp[2*k +: 2];
      end
    end
  end

  // Next-state, wait counter and master-side outputs.
  always_comb begin
    state_d     = state_q;
    dp_idx_d    = dp_idx_q;
    wcnt_d      = '0;
    m_ready     = 1'b1;
    m_resp      = RESP_OKAY;
    m_rdata     = '0;
    timeout_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_trans) begin
          state_d  = ST_DATA;
          dp_idx_d = new_idx;
        end
      end
      ST_DATA: begin
        if (dp_idx_q == DEF_IDX) begin
          m_ready = 1'b0;
          m_resp  = RESP_ERROR;
          state_d = ST_ERR1;
        end else begin
          m_ready = slv_ready;
          m_resp  = slv_resp;
          m_rdata = slv_rdata;
          if (slv_ready) begin
            if (m_trans) dp_idx_d = new_idx;
            else         state_d  = ST_IDLE;
          end else if (wcnt_q == TO_LAST) begin
            // Hung slave: abandon it and finish with a two-cycle ERROR.
            timeout_evt = 1'b1;
            state_d     = ST_ERR1;
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
        end
      end
      ST_ERR1: begin
        m_ready = 1'b0;
        m_resp  = RESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        m_resp = RESP_ERROR;
        if (m_trans) begin
          state_d  = ST_DATA;
          dp_idx_d = new_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, data-phase slave index and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dp_idx_q <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      dp_idx_q <= dp_idx_d;
      wcnt_q   <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_interconnect_n.sv
// Scoreboard bench for ahb_interconnect_n with three slaves, TIMEOUT 16.
import ahb_interconnect_n_pkg::*;

module tb_ahb_interconnect_n;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int N_SLV  = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    m_trans;
  logic [ADDR_W-1:0]       m_addr;
  logic                    m_write;
  logic [DATA_W-1:0]       m_wdata;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_ready;
  logic [1:0]              m_resp;
  logic [N_SLV-1:0]        s_sel;
  logic [ADDR_W-1:0]       s_addr;
  logic                    s_write;
  logic [DATA_W-1:0]       s_wdata;
  logic                    s_readyin;
  logic [N_SLV*DATA_W-1:0] s_rdata;
  logic [N_SLV-1:0]        s_ready;
  logic [2*N_SLV-1:0]      s_resp;
  logic                    timeout_evt;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic [1:0]        resp;
    logic              chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic dp_pend = 1'b0;

  ahb_interconnect_n #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV), .IDX_W(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .m_trans(m_trans), .m_addr(m_addr), .m_write(m_write),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .m_resp(m_resp),
    .s_sel(s_sel), .s_addr(s_addr), .s_write(s_write), .s_wdata(s_wdata),
    .s_readyin(s_readyin), .s_rdata(s_rdata), .s_ready(s_ready), .s_resp(s_resp),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slv(input int k, input logic [DATA_W-1:0] d, input logic rdy,
                         input logic [1:0] rsp);
    s_rdata[k*DATA_W +: DATA_W] = d;
    s_ready[k]                  = rdy;
    s_resp[2*k +: 2]            = rsp;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [1:0] rsp, input logic cd);
    exp_t e;
    e.rdata = d; e.resp = rsp; e.chk_data = cd;
    sb.push_back(e);
  endtask

  // Monitor: track data phases from the master's view and score completions.
  always @(negedge clk) begin
    if (rst) begin
      dp_pend = 1'b0;
      sb.delete();
    end else begin
      if (dp_pend && m_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_resp", 64'(m_resp), 64'(e.resp));
          if (e.chk_data) chk("sb_rdata", 64'(m_rdata), 64'(e.rdata));
        end
      end
      dp_pend = (m_trans && m_ready) || (dp_pend && !m_ready);
    end
  end

  initial begin
    rst = 1'b1; m_trans = 1'b0; m_addr = '0; m_write = 1'b0; m_wdata = '0;
    s_rdata = '0; s_ready = '1; s_resp = '0;

    // Reset state, with a request presented to prove s_sel is gated.
    m_trans = 1'b1; m_addr = 16'h2008;
    #2;
    chk("rst_ready", 64'(m_ready), 64'd1);
    chk("rst_resp", 64'(m_resp), 64'd0);
    chk("rst_rdata", 64'(m_rdata), 64'd0);
    chk("rst_sel", 64'(s_sel), 64'd0);
    chk("rst_tevt", 64'(timeout_evt), 64'd0);
    m_trans = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Zero-wait read of slave 0.
    set_slv(0, 32'd50, 1'b1, RESP_OKAY);
    m_trans = 1'b1; m_addr = 16'h2008; m_write = 1'b0;
    push(32'd50, RESP_OKAY, 1'b1);
    #1 chk("zw_sel", 64'(s_sel), 64'b001);
    tick();
    m_trans = 1'b0;
    chk("zw_rdata", 64'(m_rdata), 64'd50);
    chk("zw_ready", 64'(m_ready), 64'd1);
    chk("zw_resp", 64'(m_resp), 64'd0);
    tick();

    // Write to slave 1 with three wait cycles.
    set_slv(1, 32'd0, 1'b0, RESP_OKAY);
    m_trans = 1'b1; m_addr = 16'h4008; m_write = 1'b1; m_wdata = 32'd567;
    push(32'd0, RESP_OKAY, 1'b0);
    #1 chk("wr_sel", 64'(s_sel), 64'b010);
    tick();
    m_trans = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_wait_ready", 64'(m_ready), 64'd0);
      chk("wr_wdata", 64'(s_wdata), 64'd567);
      tick();
    end
    s_ready[1] = 1'b1;
    #1;
    chk("wr_done_ready", 64'(m_ready), 64'd1);
    chk("wr_done_resp", 64'(m_resp), 64'd0);
    chk("wr_done_wdata", 64'(s_wdata), 64'd567);
    tick();
    m_write = 1'b0;

    // Unmapped address -> default slave, three-cycle ERROR.
    m_trans = 1'b1; m_addr = 16'h0008;
    push(32'd0, RESP_ERROR, 1'b0);
    #1 chk("def_sel", 64'(s_sel), 64'd0);
    tick();
    m_trans = 1'b0;
    chk("def_c1_resp", 64'(m_resp), 64'd1);
    chk("def_c1_ready", 64'(m_ready), 64'd0);
    tick();
    chk("def_c2_resp", 64'(m_resp), 64'd1);
    chk("def_c2_ready", 64'(m_ready), 64'd0);
    tick();
    chk("def_c3_resp", 64'(m_resp), 64'd1);
    chk("def_c3_ready", 64'(m_ready), 64'd1);
    tick();

    // Timeout on a hung slave 2; its late ready must be ignored.
    set_slv(2, 32'd99, 1'b0, RESP_OKAY);
    m_trans = 1'b1; m_addr = 16'h6000;
    push(32'd0, RESP_ERROR, 1'b0);
    #1 chk("to_sel", 64'(s_sel), 64'b100);
    tick();
    m_trans = 1'b0;
    for (int w = 1; w <= 16; w++) begin
      chk($sformatf("to_evt_w%0d", w), 64'(timeout_evt), 64'(w == 16));
      chk($sformatf("to_ready_w%0d", w), 64'(m_ready), 64'd0);
      tick();
    end
    s_ready[2] = 1'b1;
    #1;
    chk("to_err1_ready", 64'(m_ready), 64'd0);
    chk("to_err1_resp", 64'(m_resp), 64'd1);
    chk("to_err1_evt", 64'(timeout_evt), 64'd0);
    tick();
    chk("to_err2_ready", 64'(m_ready), 64'd1);
    chk("to_err2_resp", 64'(m_resp), 64'd1);
    tick();
    chk("to_idle_resp", 64'(m_resp), 64'd0);
    chk("to_idle_rdata", 64'(m_rdata), 64'd0);

    // Pipelined reads: slave 0 then slave 1 in consecutive cycles.
    set_slv(0, 32'd50, 1'b1, RESP_OKAY);
    set_slv(1, 32'd434, 1'b1, RESP_OKAY);
    m_trans = 1'b1; m_addr = 16'h2008;
    push(32'd50, RESP_OKAY, 1'b1);
    tick();
    m_addr = 16'h4008;
    push(32'd434, RESP_OKAY, 1'b1);
    #1 chk("b2b_sel", 64'(s_sel), 64'b010);
    chk("b2b_first", 64'(m_rdata), 64'd50);
    tick();
    m_trans = 1'b0;
    chk("b2b_second", 64'(m_rdata), 64'd434);
    chk("b2b_ready", 64'(m_ready), 64'd1);
    tick();

    // RETRY response from slave 1 passes straight through.
    set_slv(1, 32'd7, 1'b1, RESP_RETRY);
    m_trans = 1'b1; m_addr = 16'h4010;
    push(32'd7, RESP_RETRY, 1'b1);
    tick();
    m_trans = 1'b0;
    chk("retry_resp", 64'(m_resp), 64'(RESP_RETRY));
    tick();
    set_slv(1, 32'd0, 1'b1, RESP_OKAY);

    // Reset asserted between edges during a waited phase.
    set_slv(2, 32'd0, 1'b0, RESP_OKAY);
    m_trans = 1'b1; m_addr = 16'h6000;
    push(32'd0, RESP_OKAY, 1'b0);
    tick();
    m_addr = 16'h2008;
    chk("mr_wait_ready", 64'(m_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("mr_ready", 64'(m_ready), 64'd1);
    chk("mr_resp", 64'(m_resp), 64'd0);
    chk("mr_sel", 64'(s_sel), 64'd0);
    chk("mr_tevt", 64'(timeout_evt), 64'd0);
    m_trans = 1'b0;
    tick(); tick();
    rst = 1'b0;
    set_slv(2, 32'd0, 1'b1, RESP_OKAY);
    tick();

    // Fresh transfer after reset.
    set_slv(0, 32'd77, 1'b1, RESP_OKAY);
    m_trans = 1'b1; m_addr = 16'h2008;
    push(32'd77, RESP_OKAY, 1'b1);
    tick();
    m_trans = 1'b0;
    chk("post_rst_rdata", 64'(m_rdata), 64'd77);
    tick(); tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_interconnect_n.md
# ahb_interconnect_n

Parametrised single-master, N-slave bus interconnect that sits between the master (address/data register path plus its control FSM) and the slave bank. It decodes the address-phase address into one-hot slave selects, registers the selection for the data phase, and muxes read data, ready and response back to the master. It adds a built-in default slave for unmapped addresses and a wait-state timeout that terminates a hung transfer with ERROR.

## Interface
Parameters:
- ADDR_W, 16: address width.
- DATA_W, 32: data width.
- N_SLV, 3: number of slaves, valid range 1..7.
- IDX_W, 3: decode field width. The field is m_addr[ADDR_W-1 -: IDX_W].
- TIMEOUT, 16: maximum number of consecutive wait cycles, at least 2.

Ports:
- clk, input, 1: the single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- m_trans, input, 1: master requests a transfer; address-phase valid.
- m_addr, input, ADDR_W: address-phase address.
- m_write, input, 1: 1 = write, 0 = read (address phase).
- m_wdata, input, DATA_W: write data (data phase).
- m_rdata, output, DATA_W: read data to the master.
- m_ready, output, 1: data phase complete; address phase accepted.
- m_resp, output, 2: response. 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- s_sel, output, N_SLV: one-hot address-phase select.
- s_addr, output, ADDR_W: m_addr broadcast to all slaves.
- s_write, output, 1: m_write broadcast.
- s_wdata, output, DATA_W: m_wdata broadcast.
- s_readyin, output, 1: copy of m_ready, so slaves can see address-phase acceptance.
- s_rdata, input, N_SLV*DATA_W: flattened read data; slave k occupies [k*DATA_W +: DATA_W].
- s_ready, input, N_SLV: per-slave ready.
- s_resp, input, 2*N_SLV: per-slave response, flattened the same way.
- timeout_evt, output, 1: one-cycle pulse when a timeout fires.

## Operation
- **Address decode.** Field value f = 1..N_SLV selects slave f-1. Field value 0 or f > N_SLV selects the default slave. Examples: 0x2008 → slave 0; 0x4008 → slave 1; 0x0008 → default.
- **s_sel** = decode(m_addr) when m_trans = 1, else all zeros. It is combinational.
- **Acceptance.** An address phase is accepted on a rising edge where m_trans & m_ready = 1. On acceptance, register dp_idx (the slave index, or DEF) and move to state DATA.
- **State machine states:** IDLE, DATA, ERR1, ERR2.
- **IDLE.** m_ready = 1, m_resp = OKAY, m_rdata = 0.
- **DATA with a real slave:**
  - m_ready = s_ready[dp_idx]; m_resp = s_resp[dp_idx]; m_rdata = s_rdata[dp_idx].
  - When m_ready = 1: a new accepted phase stays in DATA with the new dp_idx; otherwise go to IDLE.
- **DATA with the default slave:** go straight to ERR1 on the next edge, with m_ready = 0 and m_resp = ERROR in that DATA cycle.
- **ERR1.** m_ready = 0, m_resp = ERROR. Go to ERR2.
- **ERR2.** m_ready = 1, m_resp = ERROR. Completes the two-cycle ERROR. Then go to DATA if a new phase is accepted, else IDLE.
- **Wait counter.** wcnt counts consecutive DATA cycles with the selected s_ready = 0. It clears on s_ready = 1 and on entry to DATA.
- **Timeout.** When wcnt reaches TIMEOUT-1 while still waiting:
  - pulse timeout_evt;
  - go to ERR1, ignoring that slave from then on;
  - the late s_ready for that slave is discarded.
- **Multi-cycle responses.** Slave RETRY/SPLIT responses pass through unchanged; the block does not reissue transfers.
- **Write data.** s_wdata follows m_wdata combinationally; the master holds it for the whole data phase.

## Timing
- **Reset values.** State IDLE, dp_idx 0, wcnt 0, m_ready 1, m_resp 00, m_rdata 0, s_sel 0, timeout_evt 0.
- **Latency.** Zero-wait slave: the address phase is accepted at edge n and data completes at edge n+1. Each slave wait cycle adds one cycle.
- **Default slave.** Exactly 3 data-phase cycles (DATA, ERR1, ERR2). ERROR is visible for all three; m_ready is high only in the last.
- **Timeout.** timeout_evt is high in the TIMEOUT-th wait cycle. ERROR completes 2 cycles later.
- **Reset mid-transfer** (rst asserted at any time):
  - outputs return to reset values immediately, without waiting for clk;
  - the data phase in flight is dropped;
  - after deassertion, the first accepted edge starts a fresh address phase.
- **Back-to-back transfers.** Address phase of transfer n+1 overlaps the data phase of transfer n. s_sel for n+1 may be asserted while m_ready = 0; slaves only sample it when s_readyin = 1.

## Structure
- **Shared package:** RESP_OKAY/ERROR/RETRY/SPLIT codes, state encodings, and DEF index = all-ones of IDX_W.
- **Sub-module:** addr_decode_n (field extract → one-hot s_sel plus index/default flag), reused by future multi-master arbitration.
- **Top level:** holds the FSM, wait counter and response mux.

## Test plan
- **Zero-wait read.** Reset, then m_trans = 1, addr 0x2008, slave 0 rdata 50, ready 1, resp 00 → s_sel = 001 in the address cycle; next cycle m_rdata = 50, m_ready = 1, m_resp = 00.
- **Waited write.** Addr 0x4008, m_wdata 567, slave 1 holds ready = 0 for 3 cycles → m_ready low for 3 cycles, s_wdata = 567 throughout, completes OKAY on the 4th cycle.
- **Unmapped address.** Addr 0x0008 → s_sel = 000; m_resp = 01 for 3 cycles; m_ready = 0, 0, 1.
- **Timeout.** Slave 2 (addr 0x6000) holds ready = 0 forever, TIMEOUT = 16 → timeout_evt pulses in wait cycle 16, then the ERROR pair. A later ready = 1 from slave 2 is ignored.
- **Back-to-back and reset.**
  - Pipelined read 0x2008 then read 0x4008 (data 434) → both complete in consecutive cycles with correct data.
  - Assert rst during a waited phase → m_ready = 1, m_resp = 00, s_sel = 0 immediately.
